// File: rtl/strobe_param_ctrl.sv
// Rotary-encoder menu controller: browse/edit/push of three bounded parameters with a
// valid/ready configuration write. Optional accelerated stepping under STROBE_PARAM_ACCEL_EN.
module strobe_param_ctrl #(
  parameter int W         = 16,
  parameter int MAX0      = 1000,
  parameter int MAX1      = 100,
  parameter int MAX2      = 255,
  parameter int RST0      = 500,
  parameter int RST1      = 10,
  parameter int RST2      = 128,
  parameter int STEP_FAST = 10,
  parameter int ACCEL_WIN = 1000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enc_a,
  input  logic         enc_b,
  input  logic         btn_tick,
  output logic [1:0]   mode_sel,
  output logic         editing,
  output logic [W-1:0] param0,
  output logic [W-1:0] param1,
  output logic [W-1:0] param2,
  output logic         cfg_valid,
  input  logic         cfg_ready,
  output logic [1:0]   cfg_addr,
  output logic [W-1:0] cfg_data
);

  // cfg handshake: cfg_valid rises with cfg_addr/cfg_data and all three stay stable
  // until the cycle cfg_valid & cfg_ready is seen; cfg_ready alone has no effect.
  typedef enum logic [1:0] {BROWSE = 2'd0, EDIT = 2'd1, PUSH = 2'd2} state_t;

  localparam logic [W-1:0] MAX0_V = W'(MAX0);
  localparam logic [W-1:0] MAX1_V = W'(MAX1);
  localparam logic [W-1:0] MAX2_V = W'(MAX2);
  localparam logic [W-1:0] ONE_V  = W'(1);

  state_t         state_q, state_d;
  logic           a_d1, a_d2, b_d1;
  logic           step_evt, step_cw;
  logic [1:0]     sel_q;
  logic [W-1:0]   shadow_q, shadow_nxt;
  logic [W-1:0]   p0_q, p1_q, p2_q;
  logic [W-1:0]   cur_max, cur_param, step_mag;
  logic [W:0]     sum_ext, diff_ext;
  logic           cfg_valid_q;
  logic [1:0]     cfg_addr_q;
  logic [W-1:0]   cfg_data_q;

  assign step_evt = a_d2 & ~a_d1;
  assign step_cw  = b_d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_d1 <= 1'b0;
      a_d2 <= 1'b0;
      b_d1 <= 1'b0;
    end else begin
      a_d1 <= enc_a;
      a_d2 <= a_d1;
      b_d1 <= enc_b;
    end
  end

`ifdef STROBE_PARAM_ACCEL_EN
  localparam int GAP_W = $clog2(ACCEL_WIN + 1);
  localparam logic [GAP_W-1:0] WIN_V = GAP_W'(ACCEL_WIN);
  logic [GAP_W-1:0] gap_q;
  logic             prev_cw_q;

  // Gap and direction track every detected detent, even ones dropped by the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q     <= WIN_V;
      prev_cw_q <= 1'b1;
    end else if (step_evt) begin
      gap_q     <= '0;
      prev_cw_q <= step_cw;
    end else if (gap_q < WIN_V) begin
      gap_q <= gap_q + 1'b1;
    end
  end

  assign step_mag = ((gap_q < WIN_V) && (step_cw == prev_cw_q)) ? W'(STEP_FAST) : ONE_V;
`else
  assign step_mag = ONE_V;
`endif

  always_comb begin
    cur_max   = MAX0_V;
    cur_param = p0_q;
    case (sel_q)
      2'd1: begin cur_max = MAX1_V; cur_param = p1_q; end
      2'd2: begin cur_max = MAX2_V; cur_param = p2_q; end
      default: ;
    endcase
  end

  // Extended-width arithmetic so overflow and underflow are both visible before clamping.
  always_comb begin
    sum_ext  = {1'b0, shadow_q} + {1'b0, step_mag};
    diff_ext = {1'b0, shadow_q} - {1'b0, step_mag};
    if (step_cw)
      shadow_nxt = (sum_ext > {1'b0, cur_max}) ? cur_max : sum_ext[W-1:0];
    else
      shadow_nxt = (diff_ext[W] || (diff_ext == '0)) ? ONE_V : diff_ext[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BROWSE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BROWSE:  if (btn_tick) state_d = EDIT;
      EDIT:    if (btn_tick) state_d = PUSH;
      PUSH:    if (cfg_valid_q && cfg_ready) state_d = BROWSE;
      default: state_d = BROWSE;
    endcase
  end

  always_comb begin
    editing = (state_q == EDIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= 2'd0;
      shadow_q    <= '0;
      p0_q        <= W'(RST0);
      p1_q        <= W'(RST1);
      p2_q        <= W'(RST2);
      cfg_valid_q <= 1'b0;
      cfg_addr_q  <= 2'd0;
      cfg_data_q  <= '0;
    end else begin
      case (state_q)
        BROWSE: begin
          if (btn_tick)
            shadow_q <= cur_param;
          else if (step_evt) begin
            if (step_cw) sel_q <= (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
            else         sel_q <= (sel_q == 2'd0) ? 2'd2 : sel_q - 2'd1;
          end
        end
        EDIT: begin
          if (btn_tick) begin
            case (sel_q)
              2'd1:    p1_q <= shadow_q;
              2'd2:    p2_q <= shadow_q;
              default: p0_q <= shadow_q;
            endcase
            cfg_valid_q <= 1'b1;
            cfg_addr_q  <= sel_q;
            cfg_data_q  <= shadow_q;
          end else if (step_evt) begin
            shadow_q <= shadow_nxt;
          end
        end
        PUSH: begin
          if (cfg_valid_q && cfg_ready) cfg_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mode_sel  = sel_q;
  assign param0    = p0_q;
  assign param1    = p1_q;
  assign param2    = p2_q;
  assign cfg_valid = cfg_valid_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_data  = cfg_data_q;

endmodule

// File: tb/tb_strobe_param_ctrl.sv
// Bench for strobe_param_ctrl: directed detent/button sequences against a transaction-level
// menu model, checked every cycle, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_strobe_param_ctrl;
  localparam int W      = 16;
  localparam int TB_WIN = 200;
  localparam int FAST   = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enc_a = 1'b1;
  logic         enc_b = 1'b0;
  logic         btn_tick = 1'b0;
  logic         cfg_ready = 1'b0;
  logic [1:0]   mode_sel;
  logic         editing;
  logic [W-1:0] param0, param1, param2;
  logic         cfg_valid;
  logic [1:0]   cfg_addr;
  logic [W-1:0] cfg_data;

  strobe_param_ctrl #(.W(W), .STEP_FAST(FAST), .ACCEL_WIN(TB_WIN)) dut (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .btn_tick(btn_tick),
    .mode_sel(mode_sel), .editing(editing), .param0(param0), .param1(param1),
    .param2(param2), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: 0 browse, 1 edit, 2 push.
  int     m_state, m_sel, m_shadow, m_valid, m_addr, m_data;
  int     m_param [3];
  int     m_max [3] = '{1000, 100, 255};
  longint m_last_t;
  bit     m_prev_cw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_sel = 0; m_shadow = 0;
    m_valid = 0; m_addr = 0; m_data = 0;
    m_param[0] = 500; m_param[1] = 10; m_param[2] = 128;
    m_last_t = -64'sd1000000000;
    m_prev_cw = 1'b1;
  endfunction

  // Called at the clock edge on which the DUT acts on a detent.
  function automatic void model_event(bit cw, bit dropped);
    int stp;
    stp = 1;
`ifdef STROBE_PARAM_ACCEL_EN
    if ((($time - m_last_t) / 10 - 1) < TB_WIN && cw == m_prev_cw) stp = FAST;
`endif
    m_last_t = $time;
    m_prev_cw = cw;
    if (dropped) return;
    if (m_state == 0) begin
      m_sel = cw ? (m_sel + 1) % 3 : (m_sel + 2) % 3;
    end else if (m_state == 1) begin
      m_shadow = cw ? m_shadow + stp : m_shadow - stp;
      if (m_shadow > m_max[m_sel]) m_shadow = m_max[m_sel];
      if (m_shadow < 1) m_shadow = 1;
    end
  endfunction

  function automatic void model_btn();
    if (m_state == 0) begin
      m_state = 1;
      m_shadow = m_param[m_sel];
    end else if (m_state == 1) begin
      m_state = 2;
      m_param[m_sel] = m_shadow;
      m_valid = 1; m_addr = m_sel; m_data = m_shadow;
    end
  endfunction

  task automatic detent(input bit cw, input int gap);
    @(negedge clk); enc_b = cw;
    @(negedge clk); enc_a = 1'b0;
    @(posedge clk);
    @(posedge clk); model_event(cw, m_state == 2);
    @(negedge clk); enc_a = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic press();
    @(negedge clk); btn_tick = 1'b1;
    @(posedge clk); model_btn();
    @(negedge clk); btn_tick = 1'b0;
  endtask

  task automatic release_push();
    @(negedge clk); cfg_ready = 1'b1;
    @(posedge clk);
    if (m_valid != 0) begin m_valid = 0; m_state = 0; end
    @(negedge clk); cfg_ready = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (chk_en) begin
        check("mode_sel", 32'(mode_sel), 32'(m_sel));
        check("editing", 32'(editing), 32'(m_state == 1));
        check("param0", 32'(param0), 32'(m_param[0]));
        check("param1", 32'(param1), 32'(m_param[1]));
        check("param2", 32'(param2), 32'(m_param[2]));
        check("cfg_valid", 32'(cfg_valid), 32'(m_valid));
        if (m_valid != 0) begin
          check("cfg_addr", 32'(cfg_addr), 32'(m_addr));
          check("cfg_data", 32'(cfg_data), 32'(m_data));
        end
      end
    end
  end

  int exp_accel;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_param0", 32'(param0), 32'd500);
    check("rst_param1", 32'(param1), 32'd10);
    check("rst_param2", 32'(param2), 32'd128);
    check("rst_mode_sel", 32'(mode_sel), 32'd0);
    check("rst_valid", 32'(cfg_valid), 32'd0);

    // Browse wrap and forward steps.
    detent(1'b0, 3);
    check("browse_ccw_wrap", 32'(mode_sel), 32'd2);
    detent(1'b1, 3);
    detent(1'b1, 3);
    check("browse_cw2", 32'(mode_sel), 32'd1);

    // Button coincident with a CW detent: button wins.
    @(negedge clk); enc_b = 1'b1;
    @(negedge clk); enc_a = 1'b0;
    @(posedge clk);
    @(negedge clk); btn_tick = 1'b1;
    @(posedge clk); model_event(1'b1, 1'b1); model_btn();
    @(negedge clk); btn_tick = 1'b0; enc_a = 1'b1;
    check("coincide_editing", 32'(editing), 32'd1);
    check("coincide_sel", 32'(mode_sel), 32'd1);

    // Edit param1: five slow CW detents.
    repeat (300) @(negedge clk);
    for (int i = 0; i < 5; i++) detent(1'b1, 300);
    check("edit_param1_unchanged", 32'(param1), 32'd10);
    press();
    check("push_valid", 32'(cfg_valid), 32'd1);
    check("push_addr", 32'(cfg_addr), 32'd1);
    check("push_data", 32'(cfg_data), 32'd15);
    check("push_param1", 32'(param1), 32'd15);
    release_push();
    check("hs_valid_low", 32'(cfg_valid), 32'd0);
    check("hs_browse", 32'(editing), 32'd0);

    // Upper saturation on param2.
    detent(1'b1, 2);
    press();
    for (int i = 0; i < 200; i++) detent(1'b1, 1);
    press();
    check("sat_hi_data", 32'(cfg_data), 32'd255);
    release_push();

    // Lower saturation on param1.
    detent(1'b0, 2);
    press();
    for (int i = 0; i < 15; i++) detent(1'b0, 1);
    press();
    check("sat_lo_data", 32'(cfg_data), 32'd1);
    release_push();

    // Backpressure: detents and button during PUSH are dropped.
    press();
    detent(1'b1, 2);
    press();
    check("bp_data0", 32'(cfg_data), 32'd2);
    detent(1'b1, 0);
    press();
    detent(1'b0, 0);
    check("bp_valid", 32'(cfg_valid), 32'd1);
    check("bp_data", 32'(cfg_data), 32'd2);
    check("bp_param1", 32'(param1), 32'd2);
    check("bp_sel", 32'(mode_sel), 32'd1);
    release_push();
    repeat (5) @(negedge clk);
    check("bp_once", 32'(cfg_valid), 32'd0);

    // Accelerated stepping on param0.
    detent(1'b0, 2);
    press();
    repeat (300) @(negedge clk);
    for (int i = 0; i < 3; i++) detent(1'b1, 96);
    press();
`ifdef STROBE_PARAM_ACCEL_EN
    exp_accel = 521;
`else
    exp_accel = 503;
`endif
    check("accel_data", 32'(cfg_data), 32'(exp_accel));
    release_push();
    press();
    repeat (300) @(negedge clk);
    detent(1'b1, 96);
    detent(1'b0, 2);
    press();
    check("accel_net0", 32'(cfg_data), 32'(exp_accel));
    release_push();

    // Reset in the middle of a pending write.
    press();
    press();
    check("pre_rst_valid", 32'(cfg_valid), 32'd1);
    @(negedge clk); rst_n = 1'b0; model_reset();
    repeat (3) @(negedge clk);
    check("mid_rst_param0", 32'(param0), 32'd500);
    check("mid_rst_param1", 32'(param1), 32'd10);
    check("mid_rst_param2", 32'(param2), 32'd128);
    check("mid_rst_valid", 32'(cfg_valid), 32'd0);
    cfg_ready = 1'b1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_no_write", 32'(cfg_valid), 32'd0);
    check("post_rst_editing", 32'(editing), 32'd0);
    cfg_ready = 1'b0;
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
